// File: rtl/bias_group_sequencer_pkg.sv
// rtl/bias_group_sequencer_pkg.sv - shared lane width, saturation limits and FSM states
package bias_group_sequencer_pkg;

  localparam int W = 18;
  localparam int SUM_W = W + 1;

  localparam logic [W-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [W-1:0] SAT_MIN = 18'h20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bias_group_sequencer_if.sv
// rtl/bias_group_sequencer_if.sv - control, bias bank and vector stream bundle
interface bias_group_sequencer_if
  import bias_group_sequencer_pkg::*;
#(
  parameter int N_LANES  = 16,
  parameter int N_GROUPS = 4
) ();

  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  logic                           start;
  logic [N_GROUPS*N_LANES*W-1:0]  bias_bank;
  logic [N_LANES*W-1:0]           in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [N_LANES*W-1:0]           out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [GW-1:0]                  group_idx;
  logic                           busy;
  logic                           done;

  modport master (
    output start, bias_bank, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, group_idx, busy, done
  );

  modport slave (
    input  start, bias_bank, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, group_idx, busy, done
  );

endinterface

// File: rtl/bias_group_sequencer_bias_sat_add.sv
// rtl/bias_group_sequencer_bias_sat_add.sv - one lane of signed add with saturation
module bias_sat_add
  import bias_group_sequencer_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [SUM_W-1:0] sum;

  assign sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // Top two bits disagree only on overflow; the extra sign bit tells the direction.
  always_comb begin
    sum_o = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      sum_o = sum[W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/bias_group_sequencer.sv
// rtl/bias_group_sequencer.sv - steps bias groups over pixels, adds saturated bias per lane
module bias_group_sequencer
  import bias_group_sequencer_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 4,
  parameter int N_PIXELS     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  bias_group_sequencer_if.slave   bus
);

  localparam int VW = N_adder_tree * W;
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int PW = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(N_PIXELS - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [VW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  logic [VW-1:0]   bias_sel;
  logic [VW-1:0]   sum_vec;
  logic            in_ready;
  logic            in_fire;
  logic            out_fire;

  // Bias follows the group register at acceptance; a wrap only affects the next vector.
  assign bias_sel = bus.bias_bank[grp_q*VW +: VW];

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_sat_add u_add (
      .a_i   (bus.in_data[i*W +: W]),
      .b_i   (bias_sel[i*W +: W]),
      .sum_o (sum_vec[i*W +: W])
    );
  end

  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign in_fire  = in_ready && bus.in_valid;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      grp_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      grp_q       <= grp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    grp_d       = grp_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      out_data_d  = sum_vec;
      out_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pix_d   = '0;
          grp_d   = '0;
        end
      end
      RUN: begin
        if (in_fire) begin
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (grp_q == GRP_LAST) begin
              state_d = DRAIN;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.group_idx = grp_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DRAIN) && out_fire;

endmodule

// File: tb/tb_bias_group_sequencer.sv
// tb/tb_bias_group_sequencer.sv - directed stimulus with queued expectations and output monitor
module tb_bias_group_sequencer;
  import bias_group_sequencer_pkg::*;

  localparam int NL = 16;
  localparam int NG = 4;
  localparam int NP = 2;
  localparam int VW = NL * W;
  localparam int BW = NG * VW;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } exp_t;

  logic clk;
  logic rst;

  bias_group_sequencer_if #(.N_LANES(NL), .N_GROUPS(NG)) bus ();

  bias_group_sequencer #(
    .N_adder_tree (NL),
    .N_GROUPS     (NG),
    .N_PIXELS     (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  int acc = 0;
  int pass_no = 0;
  int mon_idx = 0;
  int done_cnt = 0;
  logic [BW-1:0] bank1, bank2;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] sat_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 131071) return 18'h1FFFF;
    if (s < -131072) return 18'h20000;
    return s[W-1:0];
  endfunction

  function automatic logic [VW-1:0] model(input logic [VW-1:0] v, input int g, input logic [BW-1:0] bank);
    logic [VW-1:0] r;
    for (int l = 0; l < NL; l++) begin
      r[l*W +: W] = sat_ref(v[l*W +: W], bank[(g*NL + l)*W +: W]);
    end
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [VW-1:0] d, input logic ordy, input logic st, output logic accepted);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.start     = st;
    #1;
    accepted = v && bus.in_ready;
    if (accepted) begin
      e.data = model(d, acc / NP, bus.bias_bank);
      e.last = (acc == NG*NP - 1);
      exp_q.push_back(e);
      acc++;
    end
  endtask

  task automatic send_vec(input logic [VW-1:0] d, input logic st);
    logic a;
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1, d, 1'b1, (t == 0) ? st : 1'b0, a);
      if (a) return;
    end
    total++; bad++;
    $display("FAIL send_timeout: got no in_ready want accept within 20 cycles");
  endtask

  task automatic wait_idle();
    logic a;
    for (int t = 0; t < 20; t++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      if (!bus.busy) return;
    end
    total++; bad++;
    $display("FAIL idle_timeout: got busy=1 want busy=0 within 20 cycles");
  endtask

  task automatic start_pass(input int p);
    logic a;
    pass_no = p;
    mon_idx = 0;
    acc = 0;
    cyc(1'b0, '0, 1'b1, 1'b1, a);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  VW'(bus.in_ready),  '0);
    check({tag, "_out_valid"}, VW'(bus.out_valid), '0);
    check({tag, "_out_data"},  bus.out_data,       '0);
    check({tag, "_group_idx"}, VW'(bus.group_idx), '0);
    check({tag, "_busy"},      VW'(bus.busy),      '0);
    check({tag, "_done"},      VW'(bus.done),      '0);
  endtask

  // Output monitor: samples settled signals just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: got %0h want no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("done_at_out", VW'(bus.done), VW'(e.last));
            if (pass_no == 1 && mon_idx == 0) check("p1_lane0_g0", VW'(bus.out_data[W-1:0]), VW'(18'h008D0));
            if (pass_no == 1 && mon_idx == 6) check("p1_lane0_g3", VW'(bus.out_data[W-1:0]), VW'(18'h014D0));
            if (pass_no == 2 && mon_idx == 0) check("sat_pos", VW'(bus.out_data[W-1:0]), VW'(18'h1FFFF));
            if (pass_no == 2 && mon_idx == 2) check("sat_neg", VW'(bus.out_data[W-1:0]), VW'(18'h20000));
          end
          mon_idx++;
        end else if (bus.done) begin
          total++; bad++;
          $display("FAIL done_without_out: got done=1 want done=0");
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [VW-1:0] v;
    logic [VW-1:0] held;
    logic [VW-1:0] p2 [8];
    logic [VW-1:0] p3 [8];

    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < NL; l++) begin
        bank1[(g*NL + l)*W +: W] = 18'h008D0 + 18'(g * 'h400) + 18'(l * 'h13);
      end
    end
    bank2 = bank1;
    bank2[0 +: W]    = 18'h00100;
    bank2[VW +: W]   = 18'h3F000;

    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < NL; l++) begin
        if (k < 2)      p2[k][l*W +: W] = 18'h1FFF0;
        else if (k < 4) p2[k][l*W +: W] = 18'h20010;
        else            p2[k][l*W +: W] = 18'(18'h12345 + k * 'h777 + l * 'h101);
        p3[k][l*W +: W] = 18'(k * 'h0AB1 + l * 'h1357 + 'h3A000);
      end
    end

    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus.bias_bank = bank1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("reset");

    for (int t = 0; t < 3; t++) begin
      cyc(1'b1, p3[t], 1'b1, 1'b0, a);
      check("idle_in_ready", VW'(a), '0);
      check("idle_busy", VW'(bus.busy), '0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    check("idle_out_valid", VW'(bus.out_valid), '0);
    check("idle_group", VW'(bus.group_idx), '0);

    start_pass(1);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    check("busy_after_start", VW'(bus.busy), VW'(1'b1));
    for (int k = 0; k < 8; k++) begin
      send_vec('0, (k == 3) ? 1'b1 : 1'b0);
    end
    wait_idle();
    check("p1_done_cnt", VW'(done_cnt), VW'(1));
    check("p1_q_empty", VW'(exp_q.size()), '0);

    bus.bias_bank = bank2;
    start_pass(2);
    for (int k = 0; k < 8; k++) begin
      send_vec(p2[k], 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      check("gap_group_idx", VW'(bus.group_idx), VW'(((k + 1) / NP > NG - 1) ? NG - 1 : (k + 1) / NP));
    end
    wait_idle();
    check("p2_done_cnt", VW'(done_cnt), VW'(2));

    bus.bias_bank = bank1;
    start_pass(3);
    for (int k = 0; k < 3; k++) send_vec(p3[k], 1'b0);
    for (int t = 0; t < 5; t++) begin
      cyc(1'b1, p3[3], 1'b0, 1'b0, a);
      if (t == 0) held = bus.out_data;
      check("bp_in_ready", VW'(a), '0);
      check("bp_out_valid", VW'(bus.out_valid), VW'(1'b1));
      check("bp_out_stable", bus.out_data, held);
    end
    for (int k = 3; k < 8; k++) send_vec(p3[k], 1'b0);
    wait_idle();
    check("p3_done_cnt", VW'(done_cnt), VW'(3));
    check("p3_q_empty", VW'(exp_q.size()), '0);

    start_pass(4);
    for (int k = 0; k < 3; k++) send_vec(p3[k], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midreset");
    for (int t = 0; t < 5; t++) cyc(1'b0, '0, 1'b1, 1'b0, a);
    check("midreset_no_done", VW'(done_cnt), VW'(3));
    check("midreset_idle", VW'(bus.busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bias_group_sequencer.md
# bias_group_sequencer

Sequences per-output-channel bias addition for one convolution layer. Accumulator vectors of `N_adder_tree` lanes arrive from the adder trees. The block selects the matching 18-bit bias group from a flattened bias bank built from the layer's `BIAS_layer*` constant blocks. It adds the bias per lane with signed saturation and steps through channel groups and pixels under a start/done handshake. It sits between the adder-tree outputs and the activation/write-back stage.

## Interface
- `N_adder_tree`, 16, lanes per vector (one bias per lane)
- `N_GROUPS`, 4, bias groups per layer (output channels / `N_adder_tree`)
- `N_PIXELS`, 64, vectors processed per group before advancing
- `W`, 18, lane width, two's complement
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a layer pass; ignored unless idle
- `bias_bank`  in  N_GROUPS*N_adder_tree*W  constant bias bank; group g occupies bits [(g+1)*N_adder_tree*W-1 : g*N_adder_tree*W]
- `in_data`  in  N_adder_tree*W  accumulator vector, lane i at [W*(i+1)-1:W*i]
- `in_valid`  in  1  in_data valid
- `in_ready`  out  1  block accepts in_data this cycle
- `out_data`  out  N_adder_tree*W  biased, saturated vector
- `out_valid`  out  1  out_data valid
- `out_ready`  in  1  downstream accepts out_data
- `group_idx`  out  clog2(N_GROUPS)  group currently applied
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse after last vector of last group is accepted downstream

## Operation
- FSM: IDLE → RUN on `start`. RUN → DRAIN after input accepts the last vector (group N_GROUPS-1, pixel N_PIXELS-1). DRAIN → IDLE when that vector is accepted at the output; `done` pulses in that same cycle.
- Counters: `pix_cnt` 0..N_PIXELS-1 and `group_idx` 0..N_GROUPS-1, both cleared on `start`. An input transfer (`in_valid && in_ready`) increments `pix_cnt`. On wrap it increments `group_idx`. `group_idx` does not wrap inside a pass.
- Arithmetic per lane: the sum is computed in W+1 bits. If the result exceeds 2^(W-1)-1, clamp to 0x1FFFF. If it is below -2^(W-1), clamp to 0x20000.
- Bias is taken from `group_idx` at the moment of input acceptance. The group change on the wrap cycle affects only the next vector.
- `in_ready` = (state==RUN) && (!out_valid || out_ready). There is a single output register and no skid buffer.
- `in_valid` in IDLE or DRAIN is ignored, with no counter change.
- `start` while busy is ignored.
- Reset mid-pass: the pass is abandoned with no `done`, and all state returns to reset values.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `group_idx`=0, `busy`=0, `done`=0, FSM=IDLE.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 vector/cycle while `out_ready`=1.
- `out_data`/`out_valid` hold stable while `out_valid && !out_ready`.
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- Earliest `in_ready` is the cycle after `start`.

## Structure
- Shared layer package holds:
  - `W` and lane-width constants.
  - Saturation limits `SAT_MAX`=18'h1FFFF and `SAT_MIN`=18'h20000.
  - The FSM state enum (IDLE, RUN, DRAIN).
- One sub-module `bias_sat_add`: combinational W-bit add with saturation, instantiated N_adder_tree times via generate.
- Group mux, counters, FSM and output register live in the top.

## Test plan
- Reset, then `start` with N_GROUPS=4, N_PIXELS=2, zero inputs, `out_ready`=1 → 8 outputs.
  - Outputs 0–1 equal group 0 biases, e.g. lane 0 = 18'h008D0.
  - Outputs 6–7 equal group 3 biases.
  - `done` pulses once, in the cycle the 8th output transfers.
- Lane 0 input 18'h1FFF0 with bias 18'h00100 → 18'h1FFFF. Input 18'h20010 with bias 18'h3F000 → 18'h20000.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-pass → `in_ready`=0, `out_data` stable. Order and count are preserved after release.
- `in_valid` gaps (every other cycle) → `group_idx` advances only after N_PIXELS accepted vectors.
- `start` pulse during RUN → ignored. Assert `rst` mid-pass → next cycle all outputs at reset values, and no `done` pulse.
- `in_valid`=1 in IDLE without `start` → `in_ready`=0, no output, counters stay 0.
